ifd_scoreboard: RTL and testbench
=================================

# ifd_scoreboard

Synthesizable, parametrised successor to the IFD simulation checker. It sits beside `instr_decode`, snoops the fetch interface and the decoded opcode buses, and queues up to `FIFO_DEPTH` fetched words. Each decoded instruction is checked against its fetch in order. Results are exposed as error pulses, sticky flags, saturating counters and an opcode coverage bitmap, so they are usable in simulation, emulation and silicon debug.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, fetch address width
- `DATA_WIDTH`, 12, instruction word width; mem opcode is `[DW-1:DW-3]`, mem address is `[DW-4:0]`
- `FIFO_DEPTH`, 4, outstanding fetch words, power of two, at least 2
- `RD_LATENCY`, 1, cycles from `ifu_rd_req` rising edge to valid `ifu_rd_data`, range 1..4
- `CNT_WIDTH`, 16, counter width
- `START_ADDRESS`, 'o200, required `base_addr` on first instruction after reset

Ports:
- `clk`, in, 1, clock
- `reset_n`, in, 1, reset, synchronous, active-low
- `ifu_rd_req`, in, 1, fetch request
- `ifu_rd_addr`, in, ADDR_WIDTH, fetch address
- `ifu_rd_data`, in, DATA_WIDTH, fetch data
- `base_addr`, in, ADDR_WIDTH, first-instruction address
- `mem_op`, in, 6, decoded {JMP,JMS,DCA,ISZ,TAD,AND}; bit i means opcode i
- `mem_addr`, in, DATA_WIDTH-3, decoded mem operand
- `op7_op`, in, 22, decoded op7 bits; bit 0 is NOP, bits 1..21 are IAC..CLA2 in package order
- `stall`, in, 1, decoder stall
- `err_valid`, out, 1, one-cycle error pulse
- `err_code`, out, 3, lowest-numbered error this cycle
- `err_sticky`, out, 7, OR of all errors since reset
- `err_count`, out, CNT_WIDTH, saturating count of `err_valid` pulses
- `instr_count`, out, CNT_WIDTH, saturating count of checked instructions
- `cov_hit`, out, 28, sticky bit per opcode; bits [21:0] are op7, [27:22] are mem
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1, queued words

## Operation
- Request edge: `ifu_rd_req & ~req_q`. A delay line of `RD_LATENCY` stages produces `push`, which captures `ifu_rd_data` into the FIFO.
- Instruction edge: `any_op & ~any_op_q`, where `any_op = |mem_op | |op7_op`. This produces `pop`.
- Decode check on `pop`, against the FIFO head, or against the incoming word when the FIFO is empty and `push` is in the same cycle (bypass; no write):
  - op7 active: word equals the package constant for the lowest set op7 bit. NOP always passes.
  - mem active: word[DW-1:DW-3] equals the index of the set `mem_op` bit, and `mem_addr` equals word[DW-4:0].
- Error codes (sticky bit is code-1):
  - 1 MULTI_OP: at an instruction edge, more than one bit of {`mem_op`, `op7_op`} is set. The decode check is skipped.
  - 2 DECODE_MISMATCH
  - 3 NOT_ZEROED: a request edge occurs while `any_op` is 1.
  - 4 BAD_BASE: first instruction edge after reset has `base_addr` not equal to START_ADDRESS.
  - 5 OVERFLOW: `push` while full with no `pop`. The word is dropped.
  - 6 UNDERFLOW: `pop` with the FIFO empty and no bypass. No compare is made.
  - 7 STALL_CHANGE: `stall_q & stall` and the decode vector differs from the previous cycle.
- `instr_count` increments on every `pop` without MULTI_OP. `cov_hit` sets the bit of the checked opcode.
- Counters saturate at all-ones.

## Timing
- Reset values: all outputs 0, FIFO empty, delay line cleared, first-instruction flag set.
- Reset asserted mid-operation clears everything on the next edge. In-flight delay-line entries are discarded.
- Errors are detected combinationally from inputs and `_q` registers. `err_valid`, `err_code`, `err_sticky` and the counters update at the following clock edge, so error latency is 1 cycle from the triggering edge cycle.
- Simultaneous `push` and `pop`: pop sees the pre-push head, and `fifo_level` is unchanged. When full, the same-cycle pop frees the slot, so there is no OVERFLOW.
- Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits. Full means the MSBs differ and the rest are equal. Pointers wrap naturally.
- Back-to-back request edges are legal and one cycle apart minimum. Each edge has its own delay-line slot.

## Structure
- Package `ifd_pkg`:
  - op7 index localparams
  - `OP7_ENC[22]` octal constants (IAC 'o7001, CLA1 'o7200, and the rest)
  - mem opcode values 0..5
  - `err_code_e` enum
- Sub-module `ifd_sb_fifo`: parametrised synchronous FIFO with push, pop, head, level, full and empty.
- The top level holds edge detection, the delay line, the checker and the counters.

## Test plan
- After reset, `base_addr`='o200, fetch 'o7001, then `op7_op`[IAC]=1 -> no error, `instr_count`=1, `cov_hit`[1]=1.
- Fetch 'o1123, then `mem_op`[TAD]=1 with `mem_addr`='o124 -> `err_code`=2 one cycle later, `err_sticky`[1]=1, `err_count`=1.
- Five fetches with no instruction edges, FIFO_DEPTH=4 -> fifth fetch gives `err_code`=5, and `fifo_level` stays 4.
- Instruction edge with IAC and CLA1 both set -> `err_code`=1, `instr_count` unchanged.
- First instruction with `base_addr`='o177 -> `err_code`=4. A later instruction with a wrong base gives no error 4.
- RD_LATENCY=2, FIFO empty, push and pop in the same cycle with 'o7200 / CLA1 -> bypass compare passes, `fifo_level` stays 0, no UNDERFLOW.

Source files
------------

// File: rtl/ifd_pkg.sv
// Shared constants for the IFD scoreboard: op7 encodings, mem opcodes, error codes.
package ifd_pkg;

  localparam int unsigned OP7_N = 22;
  localparam int unsigned MEM_N = 6;
  localparam int unsigned ERR_N = 7;

  localparam int unsigned OP7_NOP  = 0;
  localparam int unsigned OP7_IAC  = 1;
  localparam int unsigned OP7_BSW  = 2;
  localparam int unsigned OP7_RAL  = 3;
  localparam int unsigned OP7_RTL  = 4;
  localparam int unsigned OP7_RAR  = 5;
  localparam int unsigned OP7_RTR  = 6;
  localparam int unsigned OP7_CML  = 7;
  localparam int unsigned OP7_CMA  = 8;
  localparam int unsigned OP7_CIA  = 9;
  localparam int unsigned OP7_CLL  = 10;
  localparam int unsigned OP7_CLA1 = 11;
  localparam int unsigned OP7_HLT  = 12;
  localparam int unsigned OP7_OSR  = 13;
  localparam int unsigned OP7_SKP  = 14;
  localparam int unsigned OP7_SNL  = 15;
  localparam int unsigned OP7_SZL  = 16;
  localparam int unsigned OP7_SZA  = 17;
  localparam int unsigned OP7_SNA  = 18;
  localparam int unsigned OP7_SMA  = 19;
  localparam int unsigned OP7_SPA  = 20;
  localparam int unsigned OP7_CLA2 = 21;

  // Expected fetched word for each op7 decode bit, indexed by the constants above
  localparam logic [11:0] OP7_ENC [OP7_N] = '{
    12'o7000, 12'o7001, 12'o7002, 12'o7004, 12'o7006, 12'o7010,
    12'o7012, 12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7200,
    12'o7402, 12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440,
    12'o7450, 12'o7500, 12'o7510, 12'o7600
  };

  localparam logic [2:0] MEM_AND = 3'd0;
  localparam logic [2:0] MEM_TAD = 3'd1;
  localparam logic [2:0] MEM_ISZ = 3'd2;
  localparam logic [2:0] MEM_DCA = 3'd3;
  localparam logic [2:0] MEM_JMS = 3'd4;
  localparam logic [2:0] MEM_JMP = 3'd5;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_MULTI_OP        = 3'd1,
    ERR_DECODE_MISMATCH = 3'd2,
    ERR_NOT_ZEROED      = 3'd3,
    ERR_BAD_BASE        = 3'd4,
    ERR_OVERFLOW        = 3'd5,
    ERR_UNDERFLOW       = 3'd6,
    ERR_STALL_CHANGE    = 3'd7
  } err_code_e;

  function automatic logic [4:0] op7_index(input logic [OP7_N-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = OP7_N - 1; i >= 0; i--) if (v[i]) idx = 5'(i);
    return idx;
  endfunction

  function automatic logic [2:0] mem_index(input logic [MEM_N-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MEM_N - 1; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/ifd_sb_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is the combinational read of the oldest word.
module ifd_sb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr;
  logic             rd;

  // A same-cycle pop frees the slot, so a write is accepted even when full
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + PW'(1);
      if (rd) rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/ifd_scoreboard.sv
// In-order fetch/decode scoreboard: queues fetched words and checks each decoded instruction.
module ifd_scoreboard
  import ifd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned START_ADDRESS = 'o200
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0]       ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0]       ifu_rd_data,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [5:0]                  mem_op,
  input  logic [DATA_WIDTH-4:0]       mem_addr,
  input  logic [21:0]                 op7_op,
  input  logic                        stall,
  output logic                        err_valid,
  output logic [2:0]                  err_code,
  output logic [6:0]                  err_sticky,
  output logic [CNT_WIDTH-1:0]        err_count,
  output logic [CNT_WIDTH-1:0]        instr_count,
  output logic [27:0]                 cov_hit,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned MAW = DATA_WIDTH - 3;
  localparam int unsigned OPW = MEM_N + OP7_N;

  logic                  req_q;
  logic                  any_op_q;
  logic                  stall_q;
  logic                  first_q;
  logic [MEM_N-1:0]      mem_op_q;
  logic [MAW-1:0]        mem_addr_q;
  logic [OP7_N-1:0]      op7_q;
  logic [RD_LATENCY-1:0] dl;

  logic [OPW-1:0]        ops;
  logic                  any_op;
  logic                  multi;
  logic                  req_edge;
  logic                  op_edge;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  mismatch;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] word;
  logic [4:0]            op7_idx;
  logic [2:0]            mem_idx;
  logic [ERR_N-1:0]      err_vec;
  err_code_e             code;
  logic                  unused_addr;

  // Fetch address is not part of the check
  assign unused_addr = ^ifu_rd_addr;

  assign ops      = {mem_op, op7_op};
  assign any_op   = |ops;
  assign multi    = |(ops & (ops - OPW'(1)));
  assign req_edge = ifu_rd_req & ~req_q;
  assign op_edge  = any_op & ~any_op_q;
  assign push     = dl[RD_LATENCY-1];
  assign pop      = op_edge;
  assign bypass   = pop & fifo_empty & push;

  ifd_sb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push & ~bypass),
    .pop     (pop),
    .wdata   (ifu_rd_data),
    .head    (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Decode compare against the head, or the incoming word on bypass
  always_comb begin
    mismatch = 1'b0;
    word     = bypass ? ifu_rd_data : head;
    op7_idx  = op7_index(op7_op);
    mem_idx  = mem_index(mem_op);
    if (|op7_op) begin
      mismatch = (op7_idx != 5'd0) && (word != DATA_WIDTH'(OP7_ENC[op7_idx]));
    end else begin
      mismatch = (word[DATA_WIDTH-1:DATA_WIDTH-3] != mem_idx) ||
                 (mem_addr != word[DATA_WIDTH-4:0]);
    end
  end

  always_comb begin
    err_vec    = '0;
    err_vec[0] = op_edge & multi;
    err_vec[1] = pop & ~multi & (~fifo_empty | push) & mismatch;
    err_vec[2] = req_edge & any_op;
    err_vec[3] = op_edge & first_q & (base_addr != ADDR_WIDTH'(START_ADDRESS));
    err_vec[4] = push & fifo_full & ~pop;
    err_vec[5] = pop & fifo_empty & ~push;
    err_vec[6] = stall_q & stall &
                 ({mem_op, mem_addr, op7_op} != {mem_op_q, mem_addr_q, op7_q});
  end

  always_comb begin
    code = ERR_NONE;
    for (int i = ERR_N - 1; i >= 0; i--) begin
      if (err_vec[i]) code = err_code_e'(3'(i + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q      <= 1'b0;
      any_op_q   <= 1'b0;
      stall_q    <= 1'b0;
      first_q    <= 1'b1;
      mem_op_q   <= '0;
      mem_addr_q <= '0;
      op7_q      <= '0;
      dl         <= '0;
    end else begin
      req_q      <= ifu_rd_req;
      any_op_q   <= any_op;
      stall_q    <= stall;
      mem_op_q   <= mem_op;
      mem_addr_q <= mem_addr;
      op7_q      <= op7_op;
      if (op_edge) first_q <= 1'b0;
      dl[0] <= req_edge;
      for (int i = 1; i < RD_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  // Registered error reporting, counters and coverage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_sticky  <= '0;
      err_count   <= '0;
      instr_count <= '0;
      cov_hit     <= '0;
    end else begin
      err_valid  <= |err_vec;
      err_code   <= code;
      err_sticky <= err_sticky | err_vec;
      if ((|err_vec) && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
      if (pop && !multi) begin
        cov_hit <= cov_hit | ops;
        if (instr_count != '1) instr_count <= instr_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifd_scoreboard.sv
// Directed bench for ifd_scoreboard; a second instance uses RD_LATENCY=2 for the bypass case.
module tb_ifd_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic [11:0] base_addr;
  logic [5:0]  mem_op;
  logic [8:0]  mem_addr;
  logic [21:0] op7_op;
  logic        stall;

  logic        err_valid,  err_valid2;
  logic [2:0]  err_code,   err_code2;
  logic [6:0]  err_sticky, err_sticky2;
  logic [15:0] err_count,  err_count2;
  logic [15:0] instr_count, instr_count2;
  logic [27:0] cov_hit,    cov_hit2;
  logic [2:0]  fifo_level, fifo_level2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifd_scoreboard #(.RD_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .base_addr(base_addr), .mem_op(mem_op), .mem_addr(mem_addr),
    .op7_op(op7_op), .stall(stall), .err_valid(err_valid), .err_code(err_code),
    .err_sticky(err_sticky), .err_count(err_count), .instr_count(instr_count),
    .cov_hit(cov_hit), .fifo_level(fifo_level)
  );

  ifd_scoreboard #(.RD_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .base_addr(base_addr), .mem_op(mem_op), .mem_addr(mem_addr),
    .op7_op(op7_op), .stall(stall), .err_valid(err_valid2), .err_code(err_code2),
    .err_sticky(err_sticky2), .err_count(err_count2), .instr_count(instr_count2),
    .cov_hit(cov_hit2), .fifo_level(fifo_level2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Request edge, then the word arrives one cycle later (RD_LATENCY=1)
  task automatic fetch(input logic [11:0] w);
    ifu_rd_req = 1'b1;
    step();
    ifu_rd_req  = 1'b0;
    ifu_rd_data = w;
    step();
    ifu_rd_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ifu_rd_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifu_rd_req = 0; ifu_rd_addr = '0; ifu_rd_data = '0; base_addr = 12'o200;
    mem_op = '0; mem_addr = '0; op7_op = '0; stall = 0;
    do_reset();

    check("rst_err_valid", 32'(err_valid), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_err_sticky", 32'(err_sticky), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_instr_count", 32'(instr_count), 0);
    check("rst_cov_hit", 32'(cov_hit), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);

    // IAC matches its fetch
    fetch(12'o7001);
    check("iac_level_after_fetch", 32'(fifo_level), 1);
    op7_op = 22'h000002;
    step();
    check("iac_err_valid", 32'(err_valid), 0);
    check("iac_instr_count", 32'(instr_count), 1);
    check("iac_cov_bit1", 32'(cov_hit[1]), 1);
    check("iac_level", 32'(fifo_level), 0);
    op7_op = '0;
    step();

    // TAD operand mismatch
    fetch(12'o1123);
    mem_op = 6'b000010; mem_addr = 9'o124;
    step();
    check("tad_err_valid", 32'(err_valid), 1);
    check("tad_err_code", 32'(err_code), 2);
    check("tad_sticky_bit1", 32'(err_sticky[1]), 1);
    check("tad_err_count", 32'(err_count), 1);
    check("tad_instr_count", 32'(instr_count), 2);
    mem_op = '0; mem_addr = '0;
    step();
    check("tad_pulse_clears", 32'(err_valid), 0);

    // Five fetches, no instructions: fifth overflows
    for (int i = 0; i < 4; i++) fetch(12'o7001);
    check("fill_level", 32'(fifo_level), 4);
    check("fill_no_err", 32'(err_valid), 0);
    fetch(12'o7001);
    check("ovf_err_code", 32'(err_code), 5);
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_sticky", 32'(err_sticky), 32'h12);
    check("ovf_err_count", 32'(err_count), 2);

    // IAC and CLA1 together
    op7_op = 22'h000802;
    step();
    check("multi_err_code", 32'(err_code), 1);
    check("multi_instr_count", 32'(instr_count), 2);
    op7_op = '0;
    step();

    // Reset with a request in flight; its push must be discarded
    ifu_rd_req = 1'b1;
    step();
    base_addr = 12'o177;
    do_reset();
    step();
    check("rst2_level", 32'(fifo_level), 0);
    check("rst2_sticky", 32'(err_sticky), 0);
    check("rst2_instr_count", 32'(instr_count), 0);

    // Wrong base on first instruction only
    fetch(12'o7001);
    op7_op = 22'h000002;
    step();
    check("base_err_code", 32'(err_code), 4);
    check("base_instr_count", 32'(instr_count), 1);
    op7_op = '0;
    step();
    fetch(12'o7001);
    op7_op = 22'h000002;
    step();
    check("base_second_no_err", 32'(err_valid), 0);
    op7_op = '0;
    step();

    // Instruction with nothing queued
    op7_op = 22'h000002;
    step();
    check("udf_err_code", 32'(err_code), 6);
    // Request edge while the decode bus is still active
    ifu_rd_req = 1'b1;
    step();
    check("nz_err_code", 32'(err_code), 3);
    ifu_rd_req = 1'b0; ifu_rd_data = 12'o7001; op7_op = '0;
    step();
    ifu_rd_data = '0;
    check("nz_level", 32'(fifo_level), 1);

    // Decode vector changes during a stall
    stall = 1'b1;
    step();
    check("stall_hold_no_err", 32'(err_valid), 0);
    mem_addr = 9'o5;
    step();
    check("stall_err_code", 32'(err_code), 7);
    stall = 1'b0; mem_addr = '0;
    step();

    // Full FIFO with same-cycle push and pop: no overflow
    for (int i = 0; i < 3; i++) fetch(12'o7001);
    check("full2_level", 32'(fifo_level), 4);
    ifu_rd_req = 1'b1;
    step();
    ifu_rd_req = 1'b0; ifu_rd_data = 12'o7001; op7_op = 22'h000002;
    step();
    check("full_pushpop_no_err", 32'(err_valid), 0);
    check("full_pushpop_level", 32'(fifo_level), 4);
    ifu_rd_data = '0; op7_op = '0;
    step();
    check("seg2_err_count", 32'(err_count), 4);
    check("seg2_sticky", 32'(err_sticky), 32'h6c);

    // Bypass on the RD_LATENCY=2 instance
    base_addr = 12'o200;
    do_reset();
    ifu_rd_req = 1'b1;
    step();
    ifu_rd_req = 1'b0;
    step();
    ifu_rd_data = 12'o7200; op7_op = 22'h000800;
    step();
    check("byp_err_valid", 32'(err_valid2), 0);
    check("byp_level", 32'(fifo_level2), 0);
    check("byp_instr_count", 32'(instr_count2), 1);
    check("byp_cov_hit", 32'(cov_hit2), 32'h800);
    ifu_rd_data = '0; op7_op = '0;
    step();
    check("byp_sticky", 32'(err_sticky2), 0);
    check("byp_level_after", 32'(fifo_level2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
